// File: rtl/uart_pkg.sv
// uart_pkg: shared parity encodings, TX FSM states and frame-length helper for the UART blocks.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
  function automatic int frame_ticks(input int nb_data, input int nb_stop, input int parity, input int n_ticks);
    return n_ticks * (1 + nb_data + ((parity != PAR_NONE) ? 1 : 0) + nb_stop);
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts oversample ticks and strobes on the last tick of each bit.
module uart_bit_timer #(
  parameter int N_TICKS = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_clear,
  output logic o_bit_end
);
  localparam int CW = $clog2(N_TICKS);
  logic [CW-1:0] cnt;
  assign o_bit_end = i_tick && !i_clear && cnt == CW'(N_TICKS - 1);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) cnt <= '0;
    else if (i_clear || o_bit_end) cnt <= '0;
    else if (i_tick) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a one-entry holding register for gapless frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_STOP = 1,
  parameter int PARITY  = 0,
  parameter int N_TICKS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx_ready,
  output logic               o_tx_busy,
  output logic               o_tx_done,
  output logic               o_tx
);
  tx_state_e state, state_n;
  logic [NB_DATA-1:0] shift, shift_n, hold, hold_n;
  logic [3:0] bits, bits_n;
  logic full, full_n, par, par_n, done_n, tx_n, bit_end, accept, last_data, last_stop;

  function automatic logic par_of(input logic [NB_DATA-1:0] d);
    return (PARITY == PAR_EVEN) ? ^d : ~^d;
  endfunction

  uart_bit_timer #(.N_TICKS(N_TICKS)) timer (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_tick(i_tick),
    .i_clear(state == ST_IDLE),
    .o_bit_end(bit_end)
  );

  assign o_tx_ready = !full;
  assign o_tx_busy  = state != ST_IDLE;
  assign accept     = i_tx_start && !full;
  assign last_data  = bits == 4'(NB_DATA - 1);
  assign last_stop  = bits == 4'(NB_STOP - 1);

  always_comb begin
    state_n = state;
    shift_n = shift;
    hold_n  = hold;
    full_n  = full;
    par_n   = par;
    bits_n  = bits;
    done_n  = 1'b0;
    if (accept && state != ST_IDLE) begin
      hold_n = i_tx_data;
      full_n = 1'b1;
    end
    case (state)
      ST_IDLE: if (accept) begin
        state_n = ST_START;
        shift_n = i_tx_data;
        par_n   = par_of(i_tx_data);
      end
      ST_START: if (bit_end) state_n = ST_DATA;
      ST_DATA: if (bit_end) begin
        shift_n = shift >> 1;
        bits_n  = last_data ? 4'd0 : bits + 4'd1;
        if (last_data) state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) state_n = ST_STOP;
      ST_STOP: if (bit_end) begin
        bits_n = last_stop ? 4'd0 : bits + 4'd1;
        if (last_stop) begin
          done_n  = 1'b1;
          // a start arriving on the final edge with the holding register empty skips it
          state_n = (full || accept) ? ST_START : ST_IDLE;
          shift_n = full ? hold : accept ? i_tx_data : shift;
          par_n   = full ? par_of(hold) : accept ? par_of(i_tx_data) : par;
          full_n  = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    tx_n = (state_n == ST_START) ? 1'b0 :
           (state_n == ST_DATA)  ? shift_n[0] :
           (state_n == ST_PARITY) ? par_n : 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state     <= ST_IDLE;
      shift     <= '0;
      hold      <= '0;
      full      <= 1'b0;
      par       <= 1'b0;
      bits      <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      hold      <= hold_n;
      full      <= full_n;
      par       <= par_n;
      bits      <= bits_n;
      o_tx      <= tx_n;
      o_tx_done <= done_n;
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four transmitter configurations checked tick-by-tick against a frame-level reference model.
module tb_uart_tx_frame;
  localparam int NT = 16;
  localparam int NBD [4] = '{8, 8, 8, 7};
  localparam int NST [4] = '{1, 1, 1, 2};
  localparam int PRT [4] = '{0, 2, 1, 0};
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, man_tick = 1'b0;
  logic start [4];
  logic [8:0] data [4];
  logic tx [4], ready [4], busy [4], done [4];
  bit rec [4][$];
  int done_at [4][$];
  bit done_tx [4][$];
  bit exp_q [4][$];
  int exp_done [4][$];
  bit exp_dtx [4][$];
  int nacc [4], ndone [4];
  int n_cmp = 0, n_bad = 0;

  uart_tx_frame #(.NB_DATA(8), .NB_STOP(1), .PARITY(0), .N_TICKS(NT)) d0 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[0]), .i_tx_data(data[0][7:0]),
    .o_tx_ready(ready[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]), .o_tx(tx[0]));
  uart_tx_frame #(.NB_DATA(8), .NB_STOP(1), .PARITY(2), .N_TICKS(NT)) d1 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[1]), .i_tx_data(data[1][7:0]),
    .o_tx_ready(ready[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]), .o_tx(tx[1]));
  uart_tx_frame #(.NB_DATA(8), .NB_STOP(1), .PARITY(1), .N_TICKS(NT)) d2 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[2]), .i_tx_data(data[2][7:0]),
    .o_tx_ready(ready[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]), .o_tx(tx[2]));
  uart_tx_frame #(.NB_DATA(7), .NB_STOP(2), .PARITY(0), .N_TICKS(NT)) d3 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[3]), .i_tx_data(data[3][6:0]),
    .o_tx_ready(ready[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3]), .o_tx(tx[3]));

  always #5 clk = ~clk;

  initial begin
    int gap;
    gap = 1;
    forever begin
      @(posedge clk);
      #1;
      if (!man_tick) begin
        if (gap == 0) begin
          tick = 1'b1;
          gap = $urandom_range(1, 2);
        end else begin
          tick = 1'b0;
          gap--;
        end
      end
    end
  end

  // record the line once per tick while busy, and where each done pulse lands
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          done_at[i].push_back(rec[i].size());
          done_tx[i].push_back(tx[i]);
          ndone[i]++;
        end
        if (tick && busy[i]) rec[i].push_back(tx[i]);
      end

  task automatic model_accept(input int i, input logic [8:0] d);
    bit fr[$];
    bit p;
    fr.push_back(1'b0);
    p = 1'b0;
    for (int b = 0; b < NBD[i]; b++) begin
      fr.push_back(d[b]);
      p ^= d[b];
    end
    if (PRT[i] != 0) fr.push_back(PRT[i] == 2 ? p : !p);
    for (int s = 0; s < NST[i]; s++) fr.push_back(1'b1);
    foreach (fr[k]) repeat (NT) exp_q[i].push_back(fr[k]);
    exp_done[i].push_back(exp_q[i].size());
    if (nacc[i] - ndone[i] == 1) exp_dtx[i][exp_dtx[i].size() - 1] = 1'b0;
    exp_dtx[i].push_back(1'b1);
    nacc[i]++;
  endtask

  task automatic send(input int i, input logic [8:0] d);
    bit er;
    @(posedge clk);
    #1;
    er = (nacc[i] - ndone[i]) <= 1;
    n_cmp++;
    if (ready[i] !== er) begin
      n_bad++;
      $display("FAIL ready_at_send dut%0d: got %b want %b", i, ready[i], er);
    end
    start[i] = 1'b1;
    data[i] = d;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    if (er) model_accept(i, data[i]);
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 4; i++) if (busy[i] !== 1'b0 || nacc[i] != ndone[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (c < 30000 && !all_idle()) begin
      @(posedge clk);
      c++;
    end
    #1;
    n_cmp++;
    if (c >= 30000) begin
      n_bad++;
      $display("FAIL %s idle_timeout: still busy after %0d cycles, want idle", tag, c);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      rec[i].delete(); done_at[i].delete(); done_tx[i].delete();
      exp_q[i].delete(); exp_done[i].delete(); exp_dtx[i].delete();
      nacc[i] = 0;
      ndone[i] = 0;
    end
  endtask

  task automatic check_streams(input string tag);
    wait_idle(tag);
    for (int i = 0; i < 4; i++) begin
      int diff;
      diff = -1;
      for (int k = 0; k < exp_q[i].size() && diff < 0; k++)
        if (k >= rec[i].size() || rec[i][k] != exp_q[i][k]) diff = k;
      if (diff < 0 && rec[i].size() != exp_q[i].size()) diff = exp_q[i].size();
      n_cmp++;
      if (diff >= 0) begin
        n_bad++;
        $display("FAIL %s line dut%0d: %0d ticks seen, first wrong tick %0d, want %0d ticks", tag, i, rec[i].size(), diff, exp_q[i].size());
      end
      diff = (done_at[i].size() != exp_done[i].size()) ? 0 : -1;
      for (int k = 0; k < exp_done[i].size() && diff < 0; k++) if (done_at[i][k] != exp_done[i][k]) diff = k;
      n_cmp++;
      if (diff >= 0) begin
        n_bad++;
        $display("FAIL %s done_pos dut%0d: %0d pulses seen, want %0d (pulse index %0d)", tag, i, done_at[i].size(), exp_done[i].size(), diff);
      end
      diff = (done_tx[i].size() != exp_dtx[i].size()) ? 0 : -1;
      for (int k = 0; k < exp_dtx[i].size() && diff < 0; k++) if (done_tx[i][k] != exp_dtx[i][k]) diff = k;
      n_cmp++;
      if (diff >= 0) begin
        n_bad++;
        $display("FAIL %s line_at_done dut%0d: mismatch at pulse %0d of %0d", tag, i, diff, exp_dtx[i].size());
      end
    end
    clear_all();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp += 4;
      if (tx[i] !== 1'b1) begin n_bad++; $display("FAIL reset_tx dut%0d: got %b want 1", i, tx[i]); end
      if (ready[i] !== 1'b1) begin n_bad++; $display("FAIL reset_ready dut%0d: got %b want 1", i, ready[i]); end
      if (busy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d: got %b want 0", i, busy[i]); end
      if (done[i] !== 1'b0) begin n_bad++; $display("FAIL reset_done dut%0d: got %b want 0", i, done[i]); end
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_8n1();
    int lit [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    send(0, 9'h0A5);
    wait_idle("8n1");
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (rec[0].size() <= 16 * b + 8 || rec[0][16 * b + 8] != lit[b][0]) begin
        n_bad++;
        $display("FAIL 8n1_bit%0d: got %0d want %0d", b, rec[0].size() > 16 * b + 8 ? int'(rec[0][16 * b + 8]) : -1, lit[b]);
      end
    end
    n_cmp++;
    if (done_at[0].size() != 1 || done_at[0][0] != 160) begin
      n_bad++;
      $display("FAIL 8n1_done: %0d pulses, first at tick %0d, want 1 pulse at 160", done_at[0].size(), done_at[0].size() > 0 ? done_at[0][0] : -1);
    end
    check_streams("8n1");
  endtask

  task automatic test_parity();
    send(1, 9'h007);
    send(2, 9'h007);
    wait_idle("parity");
    n_cmp += 2;
    if (rec[1].size() != 176 || rec[1][16 * 9 + 8] != 1'b1) begin
      n_bad++;
      $display("FAIL even_parity: %0d ticks, want 176 with parity bit 1", rec[1].size());
    end
    if (rec[2].size() != 176 || rec[2][16 * 9 + 8] != 1'b0) begin
      n_bad++;
      $display("FAIL odd_parity: %0d ticks, want 176 with parity bit 0", rec[2].size());
    end
    check_streams("parity");
  endtask

  task automatic test_back_to_back();
    send(0, 9'h055);
    repeat (40) @(posedge clk);
    send(0, 9'h00F);
    n_cmp++;
    if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_drop: got %b want 0", ready[0]); end
    send(0, 9'h0FF);
    wait_idle("b2b");
    n_cmp++;
    if (done_at[0].size() != 2 || done_at[0][0] != 160 || done_at[0][1] != 320 || done_tx[0][0] != 1'b0 || done_tx[0][1] != 1'b1) begin
      n_bad++;
      $display("FAIL b2b_frames: %0d done pulses, want 2 at ticks 160/320 with no idle gap", done_at[0].size());
    end
    check_streams("b2b");
  endtask

  task automatic test_end_start();
    int c;
    send(0, 9'h0C3);
    c = 0;
    while (rec[0].size() < 150 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    #1;
    man_tick = 1'b1;
    tick = 1'b0;
    while (rec[0].size() < 159 && c < 2000) begin
      tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      @(posedge clk);
      #1 c++;
    end
    n_cmp++;
    if (c >= 2000 || ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL end_start_setup: %0d ticks after %0d cycles, ready %b, want 159 ticks and ready 1", rec[0].size(), c, ready[0]);
    end
    tick = 1'b1;
    start[0] = 1'b1;
    data[0] = 9'h03C;
    @(posedge clk);
    #1;
    tick = 1'b0;
    start[0] = 1'b0;
    man_tick = 1'b0;
    model_accept(0, data[0]);
    @(negedge clk);
    n_cmp++;
    if (done[0] !== 1'b1 || tx[0] !== 1'b0 || busy[0] !== 1'b1 || ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL end_start_edge: done=%b tx=%b busy=%b ready=%b, want 1 0 1 1", done[0], tx[0], busy[0], ready[0]);
    end
    check_streams("end_start");
  endtask

  task automatic test_7n2();
    bit ok;
    send(3, 9'h041);
    wait_idle("7n2");
    ok = rec[3].size() == 160;
    for (int k = 128; k < 160 && ok; k++) if (rec[3][k] != 1'b1) ok = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL 7n2_stop: %0d ticks seen, want 160 with ticks 128..159 high", rec[3].size()); end
    check_streams("7n2");
  endtask

  task automatic test_reset_mid();
    int c;
    send(0, 9'($urandom));
    send(0, 9'($urandom));
    c = 0;
    while (rec[0].size() < 48 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_async: tx=%b ready=%b busy=%b, want 1 1 0", tx[0], ready[0], busy[0]);
    end
    n_cmp++;
    if (ndone[0] != 0) begin n_bad++; $display("FAIL reset_mid_done: got %0d pulses want 0", ndone[0]); end
    repeat (2) @(posedge clk);
    #1;
    clear_all();
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || ndone[0] != 0) begin
      n_bad++;
      $display("FAIL reset_mid_after: busy=%b done=%b pulses=%0d, want 0 0 0", busy[0], done[0], ndone[0]);
    end
    send(0, 9'($urandom));
    check_streams("reset_mid");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int i;
      i = $urandom_range(0, 3);
      send(i, 9'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 100)) @(posedge clk);
        send(i, 9'($urandom));
        if ($urandom_range(0, 1) == 1) send(i, 9'($urandom));
      end
      check_streams("random");
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      data[i] = '0;
      nacc[i] = 0;
      ndone[i] = 0;
    end
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_end_start();
    test_7n2();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, the next generation of the team's 8N1 transmitter. It serialises one frame per accepted byte, with configurable data width, stop-bit count, parity mode and oversampling ratio. A one-entry holding register allows back-to-back frames with no idle gap. It sits between the baud-tick generator (`i_tick`) and the TX pin, fed by the command/FIFO logic through a valid/ready handshake.

## Interface

Parameters:
- `NB_DATA`, 8: data bits per frame, legal range 5..9, sent LSB first.
- `NB_STOP`, 1: stop bits, 1 or 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `N_TICKS`, 16: `i_tick` pulses per bit, legal range 2..32.

Ports:
- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_tick`  in  1  baud oversample strobe, one `i_clk` cycle wide.
- `i_tx_start`  in  1  data valid.
- `i_tx_data`  in  `NB_DATA`  frame payload.
- `o_tx_ready`  out  1  holding register empty; start is accepted.
- `o_tx_busy`  out  1  FSM not in IDLE.
- `o_tx_done`  out  1  one-cycle pulse at end of frame.
- `o_tx`  out  1  serial line, idle high.

## Operation

- Reset values: `o_tx`=1, `o_tx_ready`=1, `o_tx_busy`=0, `o_tx_done`=0. Holding register empty, FSM in IDLE, tick and bit counters 0.
- Acceptance: `i_tx_start` && `o_tx_ready` at a rising edge.
  - In IDLE, the data loads straight into the shift register.
  - Otherwise, it loads into the holding register and `o_tx_ready` drops.
  - `i_tx_start` while `o_tx_ready`=0 is ignored, and the data is dropped.
- FSM states:
  - IDLE → START on acceptance.
  - START → DATA.
  - DATA → PARITY if `PARITY`≠0, else → STOP.
  - PARITY → STOP.
  - STOP → START if the holding register is full (it moves into the shift register and the holding register empties), else → IDLE.
- Bit levels: START=0; DATA=shift[0], shifting right; PARITY=^data for even, ~^data for odd; STOP=1.
- Bit timing: the tick counter runs 0..`N_TICKS`-1 and increments on `i_tick`. A bit ends on the `i_tick` with count=`N_TICKS`-1; the counter then clears and the FSM advances.
  - Every bit lasts exactly `N_TICKS` ticks.
  - The bit counter in DATA ends at `NB_DATA`-1; in STOP it ends at `NB_STOP`-1.
- `o_tx_done` pulses for every frame, including back-to-back frames.
- `o_tx_busy`=1 in all states except IDLE.

## Timing

- `o_tx` is registered. For an acceptance edge k in IDLE, `o_tx`=0 from cycle k+1.
- `o_tx_done` is registered. It is high for the one cycle after the edge that ends the last stop bit. In that same edge, `o_tx` goes to 1 (IDLE) or 0 (next START).
- Simultaneous end of frame and new `i_tx_start` with the holding register empty: `o_tx_ready`=1, so the start is accepted.
  - The new data goes directly into the shift register.
  - The FSM moves to START with no idle cycle.
- Frame length in ticks: `N_TICKS` × (1 + `NB_DATA` + (`PARITY`≠0) + `NB_STOP`).
- `i_tick` outside SEND states is ignored. The tick count restarts at 0 on entering START.
- Reset asserted mid-frame: `o_tx`=1 immediately (asynchronous), no `o_tx_done`, holding data discarded.

## Structure

- Shared package `uart_pkg`:
  - parity encodings `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`
  - FSM state encoding
  - helper function for frame length
- Sub-module `uart_bit_timer`: tick counter and bit-end strobe, parametrised by `N_TICKS`. The same module is reused by the receiver.
- Holding register and FSM stay in `uart_tx_frame`.

## Test plan

- 8N1, `N_TICKS`=16, send 0xA5: line shows 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks. `o_tx_done` pulses once, 160 ticks after start.
- 8E1, send 0x07: parity bit=1. 8O1, send 0x07: parity bit=0. Total 11 bits.
- Back-to-back: send 0x55, then 0x0F while busy. `o_tx_ready` drops. The second start bit follows the stop bit with zero idle cycles, and there are two done pulses.
- Holding register full, third `i_tx_start` with 0xFF: ignored; only two frames appear on the line.
- `NB_DATA`=7, `NB_STOP`=2, send 0x41: 1+7+2 bits, stop bits high for 32 ticks.
- Reset asserted mid-DATA: `o_tx`=1 asynchronously, `o_tx_ready`=1, `o_tx_busy`=0, no done pulse. A following send works normally.
